serial_subtractor: RTL and testbench

- Bit-serial subtractor. Accepts two WIDTH-bit unsigned operands over a valid/ready handshake and computes a - b, LSB first, one bit per clock.
- Each bit goes through a single full-subtractor cell. The borrow is held in a flip-flop between bits.
- Returns the WIDTH-bit difference and the final borrow over a second valid/ready handshake.
- It is the subtract-direction, sequential counterpart of the team's gate-level half-adder datapath. It is used where area matters more than latency.

---
 rtl/serial_subtractor_pkg.sv | 25 ++
 rtl/serial_subtractor_full_subtractor_cell.sv | 32 +++
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Width used by the default-configured block and its result record.
  localparam int DEFAULT_WIDTH = 8;

  // Operation phases of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Result record returned over the output handshake (default width).
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] diff;
    logic                     borrow;
  } result_t;

  // Bit-counter width: clog2 of the operand width, never below one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// Single-bit full subtractor built from gate primitives:
//   d    = ai ^ bi ^ bin
//   bout = (~ai & bi) | (~(ai ^ bi) & bin)
module full_subtractor_cell (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic ab_x;
  logic ai_n;
  logic ab_xn;
  logic gen_b;
  logic prop_b;

  // Difference bit: parity of all three inputs.
  xor g_x1 (ab_x, ai, bi);
  xor g_x2 (d, ab_x, bin);

  // Borrow is generated when ai=0, bi=1.
  not g_n1 (ai_n, ai);
  and g_a1 (gen_b, ai_n, bi);

  // Incoming borrow propagates when ai == bi.
  not g_n2 (ab_xn, ab_x);
  and g_a2 (prop_b, ab_xn, bin);

  or  g_o1 (bout, gen_b, prop_b);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock,
// through a single full-subtractor cell with the borrow held in a flop.
// Operands arrive on one valid/ready handshake, the result leaves on another.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] res_sr_reg;
  logic             borrow_reg;
  logic [CW-1:0]    count_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic             cell_d;
  logic             cell_bout;

  // The one and only arithmetic element: works on the current LSBs.
  full_subtractor_cell u_cell (
    .ai   (a_sr_reg[0]),
    .bi   (b_sr_reg[0]),
    .bin  (borrow_reg),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Control FSM and datapath registers; handshake flags are registered
  // alongside the state so no output follows an input combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      res_sr_reg    <= '0;
      borrow_reg    <= 1'b0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sr_reg     <= a;
            b_sr_reg     <= b;
            borrow_reg   <= 1'b0;
            count_reg    <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end

        RUN: begin
          // Result fills from the top; after WIDTH shifts bit 0 holds the LSB.
          res_sr_reg <= {cell_d, res_sr_reg[WIDTH-1:1]};
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          borrow_reg <= cell_bout;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST_BIT) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end

        DONE: begin
          // Result and borrow stay frozen until the consumer takes them;
          // in_ready only returns on the following cycle.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign diff      = res_sr_reg;
  assign borrow    = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a plain
// arithmetic reference model: diff = (a - b) mod 256, borrow = (a < b).
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clock     (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  // Reference model: integer subtraction on the unsigned operands.
  function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    result_t r;
    int      full;
    full     = int'(x) - int'(y);
    r.diff   = W'(full);
    r.borrow = (full < 0);
    return r;
  endfunction

  // Present operands at a negedge when the block is ready; returns after the
  // accepting edge with in_valid dropped.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) ok = 1'b0;
    in_valid = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges from the accept until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%h borrow=%b want 1 0 00 0",
               in_ready, out_valid, diff, borrow);
    end
    $display("reset: in_ready=%b out_valid=%b diff=%h borrow=%b", in_ready, out_valid, diff, borrow);
  endtask

  // Directed vectors with immediate consumption; latency and post-handshake ready checked.
  task automatic test_directed();
    logic [W-1:0] va [6] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h00, 8'hA5};
    logic [W-1:0] vb [6] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h01, 8'h5A};
    for (int i = 0; i < 6; i++) begin
      result_t exp;
      int      lat;
      bit      ok;
      exp = model(va[i], vb[i]);
      start_op(va[i], vb[i], ok);
      wait_valid(lat);
      total++;
      if (!ok || lat != W) begin
        bad++;
        $display("FAIL latency[%0d]: got %0d want %0d (accepted=%0d)", i, lat, W, ok);
      end
      total++;
      if (diff !== exp.diff || borrow !== exp.borrow) begin
        bad++;
        $display("FAIL directed[%0d]: a=%h b=%h got diff=%h borrow=%b want diff=%h borrow=%b",
                 i, va[i], vb[i], diff, borrow, exp.diff, exp.borrow);
      end
      out_ready = 1'b1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_in_done[%0d]: in_ready=%b want 0", i, in_ready);
      end
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL after_handshake[%0d]: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
      end
      $display("directed a=%h b=%h -> diff=%h borrow=%b lat=%0d", va[i], vb[i], exp.diff, exp.borrow, lat);
    end
  endtask

  // Result must hold steady while the consumer stalls.
  task automatic test_backpressure();
    result_t exp;
    int      lat;
    bit      ok;
    exp = model(8'h80, 8'h01);
    start_op(8'h80, 8'h01, ok);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== exp.diff || borrow !== exp.borrow) begin
        bad++;
        $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b diff=%h borrow=%b want 1 0 %h %b",
                 k, out_valid, in_ready, diff, borrow, exp.diff, exp.borrow);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    $display("backpressure a=80 b=01 -> diff=%h borrow=%b", exp.diff, exp.borrow);
  endtask

  // in_valid held high with changing operands during RUN must be ignored.
  task automatic test_ignore_in_valid();
    result_t exp;
    int      n = 0;
    exp = model(8'h3C, 8'h4D);
    in_valid = 1'b1; a = 8'h3C; b = 8'h4D;
    @(negedge clk);
    while (!out_valid && n < TMO) begin
      a = W'($urandom);
      b = W'($urandom);
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_in_run[%0d]: in_ready=%b want 0", n, in_ready);
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b0 || diff !== exp.diff || borrow !== exp.borrow || n != W) begin
      bad++;
      $display("FAIL ignore_in_valid: in_ready=%b diff=%h borrow=%b cycles=%0d want 0 %h %b %0d",
               in_ready, diff, borrow, n, exp.diff, exp.borrow, W);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("ignore_in_valid a=3c b=4d -> diff=%h borrow=%b", exp.diff, exp.borrow);
  endtask

  // Reset mid-RUN discards the operation; the next one starts clean.
  task automatic test_reset_abort();
    result_t exp;
    int      lat;
    bit      ok;
    start_op(8'h10, 8'h20, ok);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: in_ready=%b out_valid=%b diff=%h borrow=%b want 1 0 00 0",
               in_ready, out_valid, diff, borrow);
    end
    exp = model(8'h09, 8'h04);
    start_op(8'h09, 8'h04, ok);
    wait_valid(lat);
    total++;
    if (!ok || lat != W || diff !== exp.diff || borrow !== exp.borrow) begin
      bad++;
      $display("FAIL after_abort: diff=%h borrow=%b lat=%0d want %h %b %0d",
               diff, borrow, lat, exp.diff, exp.borrow, W);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("reset_abort then a=09 b=04 -> diff=%h borrow=%b", exp.diff, exp.borrow);
  endtask

  // Random operands with random consumer stalls.
  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      result_t      exp;
      int           lat;
      int           stall;
      bit           ok;
      x = W'($urandom);
      y = W'($urandom);
      exp = model(x, y);
      start_op(x, y, ok);
      wait_valid(lat);
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      total++;
      if (!ok || lat != W || out_valid !== 1'b1 || diff !== exp.diff || borrow !== exp.borrow) begin
        bad++;
        $display("FAIL random[%0d]: a=%h b=%h got diff=%h borrow=%b lat=%0d want %h %b %0d",
                 i, x, y, diff, borrow, lat, exp.diff, exp.borrow, W);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      $display("random[%0d] a=%h b=%h -> diff=%h borrow=%b stall=%0d", i, x, y, exp.diff, exp.borrow, stall);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
